alu_issue: RTL
==============

# alu_issue

Decode-and-issue stage that feeds the ALU. It accepts RV32IM integer-compute instructions with their register operands over a valid/ready handshake, and decodes each one into the ALU's `alu_op`, `in0` and `in1`. Results are registered into a 2-entry skid buffer, and a valid/ready handshake presents them to the execute stage. Placement: between register-file read and the ALU.

## Interface
- `WORD_LEN`, default 32: datapath width. Only 32 is supported.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction and operands valid.
- `in_ready`  out  1  stage can accept. Registered, equals "buffer not full".
- `inst`  in  32  instruction word.
- `pc`  in  WORD_LEN  instruction address, used by AUIPC.
- `rs1_val`, `rs2_val`  in  WORD_LEN  register operands.
- `out_valid`  out  1  decoded operation valid.
- `out_ready`  in  1  ALU/execute stage accepts.
- `alu_op`  out  5  ALU operation code.
- `in0`, `in1`  out  WORD_LEN  ALU operands.
- `illegal`  out  1  instruction is not a supported compute instruction.

## Operation
- alu_op encoding:
  - ADD=0, SUB=1, OR=2, XOR=3, AND=4
  - SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9
  - MUL=10, MULH=11, DIV=12, REM=13, DIVU=14, REMU=15
  - 16–31 reserved, never emitted.
- OP (0110011):
  - Operands: `in0`=rs1_val, `in1`=rs2_val.
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA. Any other funct3 is illegal.
  - funct7=0000001: funct3 000 MUL, 001 MULH, 100 DIV, 101 DIVU, 110 REM, 111 REMU. 010/011 (MULHSU/MULHU) are illegal.
  - Any other funct7 is illegal.
- OP-IMM (0010011):
  - Operands: `in0`=rs1_val, `in1`=sign-extended inst[31:20].
  - funct3 mapping is the same as OP with funct7=0.
  - SLLI/SRLI/SRAI: `in1`={27'b0, inst[24:20]}.
  - SLLI requires inst[31:25]=0000000.
  - funct3 101 selects by inst[31:25]: 0000000 → SRL, 0100000 → SRA. Anything else is illegal.
- LUI (0110111): ADD with `in0`=0, `in1`={inst[31:12], 12'b0}.
- AUIPC (0010111): ADD with `in0`=pc, `in1`={inst[31:12], 12'b0}.
- Illegal instructions are still issued, in order, with `illegal`=1, `alu_op`=ADD, `in0`=`in1`=0. No instruction is dropped.
- Decode is combinational on the input side. Only decoded fields are stored in the buffer entries, not `inst`.

## Timing
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N. Throughput is 1 instruction per cycle.
- Fire conditions: input fires on `in_valid && in_ready`; output fires on `out_valid && out_ready`.
- Buffer states: EMPTY, ONE (main register full), TWO (main and skid registers full).
- Transitions:
  - EMPTY: input fire → ONE.
  - ONE: input fire only → TWO, new entry goes to skid. Input and output fire together → ONE, main register reloads. Output fire only → EMPTY.
  - TWO: output fire → ONE, skid moves to main. Input cannot fire.
- `in_ready`=1 in EMPTY and ONE, 0 in TWO. It is registered and does not depend on `out_ready` combinationally.
- Output payload holds stable while `out_valid && !out_ready`.
- Output order equals input order.
- Reset: asserting `rst` at any time, including mid-stall, immediately empties the buffer. Reset values:
  - `out_valid`=0, `in_ready`=1
  - `alu_op`=0, `in0`=0, `in1`=0, `illegal`=0
  - State returns to EMPTY, and in-flight entries are discarded.
- `in_valid` while `in_ready`=0 has no effect. The source holds the instruction until it is accepted.

## Structure
- Shared package `alu_pkg`: alu_op localparams (ALU_ADD … ALU_REMU, 5-bit), opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC), and the buffer-state encoding. The ALU uses the same package for its mux keys.
- One sub-module: `alu_decode`. It is combinational, maps inst/pc/rs1_val/rs2_val to {illegal, alu_op, in0, in1}, and is verified standalone. The skid-buffer control stays in `alu_issue`.

## Test plan
- `add x1,x2,x3`: inst=0x003100B3, rs1=5, rs2=7 → one cycle later `alu_op`=0, `in0`=5, `in1`=7, `illegal`=0.
- `addi x1,x2,-1`: inst=0xFFF10093 → `in1`=0xFFFFFFFF. `srai x1,x2,3`: inst=0x40315093 → `alu_op`=7, `in1`=3. `lui x1,0x12345`: inst=0x123450B7 → `in0`=0, `in1`=0x12345000.
- Back-pressure: hold `out_ready`=0 and drive 3 back-to-back instructions. Required: `in_ready` drops after 2 are accepted and the payload stays on the first. Then assert `out_ready` → the three emerge in order, one per cycle.
- Streaming: `in_valid`=`out_ready`=1 for 20 cycles → 20 outputs, no bubbles after the first, state stays ONE.
- Illegal: inst=0xFFFFFFFF, and inst=0x02312033 (MULHSU) → `illegal`=1, `alu_op`=0, `in0`=`in1`=0, issued in order.
- Reset in state TWO: assert `rst` asynchronously → `out_valid`=0 and `in_ready`=1 before the next edge. After release, the next accepted instruction is the first output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32 opcodes, issue-buffer state
// encoding and the decoded entry layout held by the issue stage.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_XOR  = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;
    localparam logic [4:0] ALU_MULH = 5'd11;
    localparam logic [4:0] ALU_DIV  = 5'd12;
    localparam logic [4:0] ALU_REM  = 5'd13;
    localparam logic [4:0] ALU_DIVU = 5'd14;
    localparam logic [4:0] ALU_REMU = 5'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic        illegal;
        logic [4:0]  alu_op;
        logic [31:0] in0;
        logic [31:0] in1;
    } issue_entry_t;

    // funct3 mapping shared by OP (funct7=0) and OP-IMM
    function automatic logic [4:0] base_op(input logic [2:0] funct3);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an RV32IM compute instruction into ALU operation
// and operands; unsupported encodings come out as a zeroed ADD flagged illegal.
module alu_decode
    import alu_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic [31:0]         inst,
    input  logic [WORD_LEN-1:0] pc,
    input  logic [WORD_LEN-1:0] rs1_val,
    input  logic [WORD_LEN-1:0] rs2_val,
    output logic                illegal,
    output logic [4:0]          alu_op,
    output logic [WORD_LEN-1:0] in0,
    output logic [WORD_LEN-1:0] in1
);

    logic [6:0]          opcode_s;
    logic [2:0]          funct3_s;
    logic [6:0]          funct7_s;
    logic [WORD_LEN-1:0] imm_i_s;
    logic [WORD_LEN-1:0] imm_u_s;
    logic [WORD_LEN-1:0] shamt_s;
    logic                illegal_s;
    logic [4:0]          op_s;
    logic [WORD_LEN-1:0] in0_s;
    logic [WORD_LEN-1:0] in1_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign funct7_s = inst[31:25];
    assign imm_i_s  = {{(WORD_LEN-12){inst[31]}}, inst[31:20]};
    assign imm_u_s  = {inst[31:12], 12'b0};
    assign shamt_s  = {{(WORD_LEN-5){1'b0}}, inst[24:20]};

    // Opcode/funct decode into operation and raw operands
    always_comb begin
        illegal_s = 1'b0;
        op_s      = ALU_ADD;
        in0_s     = rs1_val;
        in1_s     = rs2_val;
        case (opcode_s)
            OPC_OP: begin
                case (funct7_s)
                    7'b0000000: op_s = base_op(funct3_s);
                    7'b0100000: begin
                        case (funct3_s)
                            3'b000:  op_s = ALU_SUB;
                            3'b101:  op_s = ALU_SRA;
                            default: illegal_s = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        case (funct3_s)
                            3'b000:  op_s = ALU_MUL;
                            3'b001:  op_s = ALU_MULH;
                            3'b100:  op_s = ALU_DIV;
                            3'b101:  op_s = ALU_DIVU;
                            3'b110:  op_s = ALU_REM;
                            3'b111:  op_s = ALU_REMU;
                            default: illegal_s = 1'b1;
                        endcase
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                in1_s = imm_i_s;
                case (funct3_s)
                    3'b001: begin
                        in1_s = shamt_s;
                        if (funct7_s == 7'b0000000) begin
                            op_s = ALU_SLL;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    3'b101: begin
                        in1_s = shamt_s;
                        case (funct7_s)
                            7'b0000000: op_s = ALU_SRL;
                            7'b0100000: op_s = ALU_SRA;
                            default:    illegal_s = 1'b1;
                        endcase
                    end
                    default: op_s = base_op(funct3_s);
                endcase
            end
            OPC_LUI: begin
                in0_s = '0;
                in1_s = imm_u_s;
            end
            OPC_AUIPC: begin
                in0_s = pc;
                in1_s = imm_u_s;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign illegal = illegal_s;
    assign alu_op  = illegal_s ? ALU_ADD : op_s;
    assign in0     = illegal_s ? '0 : in0_s;
    assign in1     = illegal_s ? '0 : in1_s;

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes incoming instructions and holds them in a
// two-entry skid buffer (main + skid) presented to the ALU over valid/ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst,
    input  logic [WORD_LEN-1:0] pc,
    input  logic [WORD_LEN-1:0] rs1_val,
    input  logic [WORD_LEN-1:0] rs2_val,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          alu_op,
    output logic [WORD_LEN-1:0] in0,
    output logic [WORD_LEN-1:0] in1,
    output logic                illegal
);

    buf_state_e   state_q, state_d;
    issue_entry_t main_q, main_d;
    issue_entry_t skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    issue_entry_t dec_s;
    logic         in_fire_s;
    logic         out_fire_s;

    alu_decode #(.WORD_LEN(WORD_LEN)) u_decode (
        .inst    (inst),
        .pc      (pc),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .illegal (dec_s.illegal),
        .alu_op  (dec_s.alu_op),
        .in0     (dec_s.in0),
        .in1     (dec_s.in1)
    );

    assign in_fire_s  = in_valid && in_ready_q;
    assign out_fire_s = out_valid_q && out_ready;

    // Buffer next-state: main always holds the oldest entry, skid the younger
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (in_fire_s) begin
                    main_d  = dec_s;
                    state_d = BUF_ONE;
                end else begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_d  = dec_s;
                    state_d = BUF_ONE;
                end else if (in_fire_s) begin
                    skid_d  = dec_s;
                    state_d = BUF_TWO;
                end else if (out_fire_s) begin
                    state_d = BUF_EMPTY;
                end else begin
                    state_d = BUF_ONE;
                end
            end
            BUF_TWO: begin
                if (out_fire_s) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end else begin
                    state_d = BUF_TWO;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        in_ready_d  = (state_d != BUF_TWO);
        out_valid_d = (state_d != BUF_EMPTY);
    end

    // State, handshake flags and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_op    = main_q.alu_op;
    assign in0       = main_q.in0;
    assign in1       = main_q.in1;
    assign illegal   = main_q.illegal;

endmodule
